// File: rtl/mem_ctrl.sv
// Line-granular memory controller: serialises icache/dcache 16-byte line reads and
// dcache write-backs into byte accesses on a registered-read RAM/IO bus.
module mem_ctrl #(
  parameter int          LINE_BYTES = 16,
  parameter logic [1:0]  IO_HI      = 2'b11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         io_buffer_full,
  input  logic         ic_rd_ena,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_valid,
  output logic [127:0] ic_rd_line,
  input  logic         dc_wr_ena,
  input  logic [31:0]  dc_wr_addr,
  input  logic [127:0] dc_wr_line,
  input  logic         dc_rd_ena,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_valid,
  output logic [127:0] dc_rd_line,
  input  logic [7:0]   ram_din,
  output logic [7:0]   ram_dout,
  output logic [31:0]  ram_a,
  output logic         ram_wr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  localparam logic [4:0] LAST_BYTE = 5'(LINE_BYTES - 1);
  localparam logic [4:0] LAST_CAP  = 5'(LINE_BYTES + 1);

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  logic [4:0]     cnt_q, cnt_d, cnt_nx;
  logic [31:0]    base_q, base_d;
  logic [31:0]    ram_a_q, ram_a_d;
  logic [7:0]     ram_dout_q, ram_dout_d;
  logic           ram_wr_q, ram_wr_d;
  logic           ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d;
  logic [127:0]   ic_line_q, ic_line_d, dc_line_q, dc_line_d;
  logic           rdy_q;
  logic [7:0]     din_hold_q, din_hold_d, din;
  logic [3:0]     cap_idx;
  logic           io_stall;

  // The RAM keeps answering while rdy is low, so the byte in flight at the first
  // frozen edge is parked and replayed on the first edge after rdy returns.
  assign din        = rdy_q ? ram_din : din_hold_q;
  assign din_hold_d = rdy_q ? ram_din : din_hold_q;
  assign io_stall   = ram_wr_q && (ram_a_q[17:16] == IO_HI) && io_buffer_full;
  assign cap_idx    = cnt_q[3:0] - 4'd2;
  assign cnt_nx     = cnt_q + 5'd1;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;
    ic_valid_d = 1'b0;
    dc_valid_d = 1'b0;
    ic_line_d  = ic_line_q;
    dc_line_d  = dc_line_q;
    unique case (state_q)
      S_IDLE: begin
        if (dc_wr_ena) begin
          base_d     = dc_wr_addr & ~32'hF;
          owner_d    = OWN_DC;
          state_d    = S_WRITE;
          cnt_d      = 5'd0;
          ram_a_d    = dc_wr_addr & ~32'hF;
          ram_dout_d = dc_wr_line[7:0];
          ram_wr_d   = 1'b1;
        end else if (dc_rd_ena || ic_rd_ena) begin
          base_d  = (dc_rd_ena ? dc_rd_addr : ic_rd_addr) & ~32'hF;
          owner_d = dc_rd_ena ? OWN_DC : OWN_IC;
          state_d = S_READ;
          cnt_d   = 5'd1;
          ram_a_d = (dc_rd_ena ? dc_rd_addr : ic_rd_addr) & ~32'hF;
        end
      end
      S_READ: begin
        // cnt_q is the next address to issue; the byte arriving now is cnt_q-2.
        if (cnt_q <= LAST_BYTE) ram_a_d = base_q + {27'd0, cnt_q};
        if (cnt_q >= 5'd2) begin
          if (owner_q == OWN_DC) dc_line_d[{cap_idx, 3'b000} +: 8] = din;
          else                   ic_line_d[{cap_idx, 3'b000} +: 8] = din;
        end
        if (cnt_q == LAST_CAP) begin
          state_d = S_DONE;
          if (owner_q == OWN_DC) dc_valid_d = 1'b1;
          else                   ic_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_nx;
        end
      end
      S_WRITE: begin
        if (!io_stall) begin
          if (cnt_q == LAST_BYTE) begin
            dc_valid_d = 1'b1;
            ram_wr_d   = 1'b0;
            state_d    = S_DONE;
          end else begin
            cnt_d      = cnt_nx;
            ram_a_d    = base_q + {27'd0, cnt_nx};
            ram_dout_d = dc_wr_line[{cnt_nx[3:0], 3'b000} +: 8];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the line registers
  // are ordinary flops and are cleared by reset like everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IC;
      cnt_q      <= 5'd0;
      base_q     <= 32'd0;
      ram_a_q    <= 32'd0;
      ram_dout_q <= 8'd0;
      ram_wr_q   <= 1'b0;
      ic_valid_q <= 1'b0;
      dc_valid_q <= 1'b0;
      ic_line_q  <= 128'd0;
      dc_line_q  <= 128'd0;
      rdy_q      <= 1'b0;
      din_hold_q <= 8'd0;
    end else begin
      rdy_q      <= rdy;
      din_hold_q <= din_hold_d;
      if (rdy) begin
        state_q    <= state_d;
        owner_q    <= owner_d;
        cnt_q      <= cnt_d;
        base_q     <= base_d;
        ram_a_q    <= ram_a_d;
        ram_dout_q <= ram_dout_d;
        ram_wr_q   <= ram_wr_d;
        ic_valid_q <= ic_valid_d;
        dc_valid_q <= dc_valid_d;
        ic_line_q  <= ic_line_d;
        dc_line_q  <= dc_line_d;
      end
    end
  end

  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;
  assign ram_wr     = ram_wr_q && rdy && !io_stall;
  assign ic_valid   = ic_valid_q;
  assign dc_valid   = dc_valid_q;
  assign ic_rd_line = ic_line_q;
  assign dc_rd_line = dc_line_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: registered-read RAM model, latency and data checks.
module tb_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst, rdy, io_buffer_full;
  logic         ic_rd_ena, dc_wr_ena, dc_rd_ena;
  logic [31:0]  ic_rd_addr, dc_wr_addr, dc_rd_addr;
  logic [127:0] dc_wr_line, ic_rd_line, dc_rd_line;
  logic         ic_valid, dc_valid, ram_wr;
  logic [7:0]   ram_din, ram_dout;
  logic [31:0]  ram_a;

  logic [7:0]   mem [0:262143];
  logic         pl_en = 1'b0;
  logic [17:0]  pl_addr = '0;
  logic [7:0]   pl_data = '0;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int both_hi = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .ic_rd_ena(ic_rd_ena), .ic_rd_addr(ic_rd_addr), .ic_valid(ic_valid),
    .ic_rd_line(ic_rd_line), .dc_wr_ena(dc_wr_ena), .dc_wr_addr(dc_wr_addr),
    .dc_wr_line(dc_wr_line), .dc_rd_ena(dc_rd_ena), .dc_rd_addr(dc_rd_addr),
    .dc_valid(dc_valid), .dc_rd_line(dc_rd_line), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr] <= pl_data;
    else if (ram_wr) mem[ram_a[17:0]] <= ram_dout;
    ram_din <= mem[ram_a[17:0]];
  end

  always @(negedge clk) if (ic_valid && dc_valid) both_hi <= both_hi + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] pat_line(input logic [7:0] b0);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = b0 + 8'(k);
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input logic [17:0] a);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = mem[a + 18'(k)];
    return l;
  endfunction

  task automatic preload(input logic [17:0] a, input logic [7:0] b0);
    for (int k = 0; k < 16; k++) begin
      pl_en = 1'b1; pl_addr = a + 18'(k); pl_data = b0 + 8'(k);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  // Waits for the chosen valid; lat is cycles since E0 (start), -1 on timeout.
  task automatic wait_valid(input bit is_ic, input int start, input int budget,
                            output int lat, output logic [31:0] a_first,
                            output logic [31:0] a_last);
    lat = -1; a_first = 'x; a_last = 'x;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cyc == start)      a_first = ram_a;
      if (cyc == start + 15) a_last  = ram_a;
      if (is_ic ? ic_valid : dc_valid) begin
        lat = cyc - start;
        return;
      end
    end
  endtask

  task automatic release_ena();
    @(posedge clk); #1;
    ic_rd_ena = 1'b0; dc_rd_ena = 1'b0; dc_wr_ena = 1'b0;
  endtask

  initial begin
    int lat, vcnt, wcnt, start;
    logic [31:0] af, al, ra0, ra1;
    logic [127:0] wl;
    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    ic_rd_ena = 1'b0; dc_wr_ena = 1'b0; dc_rd_ena = 1'b0;
    ic_rd_addr = '0; dc_wr_addr = '0; dc_rd_addr = '0; dc_wr_line = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_ic_valid", ic_valid, 0);
    check("rst_dc_valid", dc_valid, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_ic_line", ic_rd_line, 0);
    check("rst_dc_line", dc_rd_line, 0);
    rst = 1'b1;
    preload(18'h01000, 8'h00);
    preload(18'h03000, 8'hA0);
    preload(18'h04000, 8'h40);
    preload(18'h05000, 8'hC0);

    // dcache line read, unaligned address
    start = cyc + 1; dc_rd_addr = 32'h1004; dc_rd_ena = 1'b1;
    wait_valid(0, start, 100, lat, af, al);
    check("rd_lat", lat, 17);
    check("rd_line", dc_rd_line, 128'h0F0E0D0C0B0A09080706050403020100);
    check("rd_a_first", af, 32'h1000);
    check("rd_a_last", al, 32'h100F);
    release_ena();

    // write-back then read-back
    wl = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    start = cyc + 1; dc_wr_addr = 32'h2000; dc_wr_line = wl; dc_wr_ena = 1'b1;
    wait_valid(0, start, 100, lat, af, al);
    check("wr_lat", lat, 16);
    release_ena();
    check("wr_mem", mem_line(18'h02000), wl);
    start = cyc + 1; dc_rd_addr = 32'h2000; dc_rd_ena = 1'b1;
    wait_valid(0, start, 100, lat, af, al);
    check("wrrd_lat", lat, 17);
    check("wrrd_line", dc_rd_line, wl);
    release_ena();

    // arbitration: dcache first, icache waits
    start = cyc + 1;
    ic_rd_addr = 32'h3000; ic_rd_ena = 1'b1;
    dc_rd_addr = 32'h4000; dc_rd_ena = 1'b1;
    wait_valid(0, start, 100, lat, af, al);
    check("arb_dc_lat", lat, 17);
    check("arb_dc_line", dc_rd_line, pat_line(8'h40));
    @(posedge clk); #1; dc_rd_ena = 1'b0;
    wait_valid(1, start, 100, lat, af, al);
    check("arb_ic_lat", lat, 36);
    check("arb_ic_line", ic_rd_line, pat_line(8'hA0));
    check("arb_dc_hold", dc_rd_line, pat_line(8'h40));
    release_ena();

    // IO-region write with buffer full for the first 3 cycles of byte 0
    wl = 128'h0123456789ABCDEF_FEDCBA9876543210;
    wcnt = 0;
    start = cyc + 1; dc_wr_addr = 32'h30000; dc_wr_line = wl; dc_wr_ena = 1'b1;
    io_buffer_full = 1'b1;
    fork
      wait_valid(0, start, 100, lat, af, al);
      begin
        repeat (4) @(posedge clk); #1; io_buffer_full = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (ram_wr && ram_a == 32'h30000) wcnt++;
        end
      end
    join
    check("io_lat", lat, 19);
    check("io_byte0_writes", wcnt, 1);
    release_ena();
    check("io_mem", mem_line(18'h30000), wl);

    // reset in the middle of a read
    start = cyc + 1; dc_rd_addr = 32'h5000; dc_rd_ena = 1'b1;
    for (int i = 0; i < 40 && cyc < start + 7; i++) @(negedge clk);
    rst = 1'b0; #1;
    check("mrst_ram_a", ram_a, 0);
    check("mrst_dc_valid", dc_valid, 0);
    check("mrst_dc_line", dc_rd_line, 0);
    check("mrst_ram_wr", ram_wr, 0);
    dc_rd_ena = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dc_valid || ic_valid) vcnt++;
    end
    check("mrst_no_valid", vcnt, 0);
    @(posedge clk); #1; rst = 1'b1;
    start = cyc + 1; dc_rd_addr = 32'h5000; dc_rd_ena = 1'b1;
    wait_valid(0, start, 100, lat, af, al);
    check("mrst_lat", lat, 17);
    check("mrst_line", dc_rd_line, pat_line(8'hC0));
    release_ena();

    // rdy low for 5 cycles in the middle of a read
    start = cyc + 1; dc_rd_addr = 32'h1000; dc_rd_ena = 1'b1;
    ra0 = '0; ra1 = '0;
    fork
      wait_valid(0, start, 100, lat, af, al);
      begin
        repeat (6) @(posedge clk); #1; rdy = 1'b0; ra0 = ram_a;
        repeat (5) @(posedge clk); #1; ra1 = ram_a; rdy = 1'b1;
      end
    join
    check("rdy_a_frozen", ra1, ra0);
    check("rdy_a_value", ra1, 32'h1005);
    check("rdy_lat", lat, 22);
    check("rdy_line", dc_rd_line, 128'h0F0E0D0C0B0A09080706050403020100);
    release_ena();

    check("valid_overlap", both_hi, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
